// File: rtl/mc_cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, FSM states, datapath select codes
// and the control vector produced by the decoder.
package mc_cpu_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_REG = 2'b10;
   localparam logic [1:0] PC_SRC_JMP = 2'b11;

   localparam logic [1:0] REG_DST_RA = 2'b00;
   localparam logic [1:0] REG_DST_RT = 2'b01;
   localparam logic [1:0] REG_DST_RD = 2'b10;

   typedef struct packed {
      logic       pc_wre;
      logic [1:0] pc_src;
      logic       ir_wre;
      logic       ins_mem_rw;
      logic       reg_wre;
      logic [1:0] reg_dst;
      logic       wr_reg_d_src;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       ext_sel;
      logic [2:0] alu_op;
      logic       m_rd;
      logic       m_wr;
      logic       db_data_src;
   } ctrl_t;

   // Fetch stays enabled during reset so the first instruction is read from PC=0.
   localparam ctrl_t CTRL_RESET = '{
      pc_wre: 1'b0, pc_src: PC_SRC_SEQ, ir_wre: 1'b1, ins_mem_rw: 1'b1,
      reg_wre: 1'b0, reg_dst: REG_DST_RA, wr_reg_d_src: 1'b0, alu_src_a: 1'b0,
      alu_src_b: 1'b0, ext_sel: 1'b0, alu_op: ALU_ADD, m_rd: 1'b0, m_wr: 1'b0,
      db_data_src: 1'b0
   };

   function automatic logic is_alu_op(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLT, OP_SLTI};
   endfunction

   function automatic logic is_mem_op(input logic [5:0] op);
      return op inside {OP_SW, OP_LW};
   endfunction

   function automatic logic is_branch_op(input logic [5:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of (next_state, opcode, zero, sign) into the control vector
// that the top level registers alongside the state.
module mc_ctrl_decode
   import mc_cpu_pkg::*;
#(
   parameter int OPW = 6
) (
   input  state_e         next_state,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           sign,
   output ctrl_t          ctrl_d
);

   logic in_instr;

   always_comb begin
      // NOTE: every field gets a default first so no path through the decode infers a latch.
      ctrl_d   = '0;
      in_instr = !(next_state inside {S_IF, S_ID});

      // Entering IF means the previous instruction is done: advance PC and fetch.
      if (next_state == S_IF) begin
         ctrl_d.pc_wre     = 1'b1;
         ctrl_d.ir_wre     = 1'b1;
         ctrl_d.ins_mem_rw = 1'b1;
         case (opcode)
            OP_BEQ:        if (zero)  ctrl_d.pc_src = PC_SRC_BR;
            OP_BNE:        if (!zero) ctrl_d.pc_src = PC_SRC_BR;
            OP_BLTZ:       if (sign)  ctrl_d.pc_src = PC_SRC_BR;
            OP_JR:         ctrl_d.pc_src = PC_SRC_REG;
            OP_J, OP_JAL:  ctrl_d.pc_src = PC_SRC_JMP;
            default:       ctrl_d.pc_src = PC_SRC_SEQ;
         endcase
      end

      if (in_instr) begin
         case (opcode)
            OP_ADD:   begin ctrl_d.alu_op = ALU_ADD; ctrl_d.reg_dst = REG_DST_RD; end
            OP_SUB:   begin ctrl_d.alu_op = ALU_SUB; ctrl_d.reg_dst = REG_DST_RD; end
            OP_AND:   begin ctrl_d.alu_op = ALU_AND; ctrl_d.reg_dst = REG_DST_RD; end
            OP_SLT:   begin ctrl_d.alu_op = ALU_SLT; ctrl_d.reg_dst = REG_DST_RD; end
            OP_ADDIU: begin
               ctrl_d.alu_op = ALU_ADD; ctrl_d.alu_src_b = 1'b1;
               ctrl_d.ext_sel = 1'b1;  ctrl_d.reg_dst = REG_DST_RT;
            end
            OP_ANDI:  begin
               ctrl_d.alu_op = ALU_AND; ctrl_d.alu_src_b = 1'b1; ctrl_d.reg_dst = REG_DST_RT;
            end
            OP_ORI:   begin
               ctrl_d.alu_op = ALU_OR; ctrl_d.alu_src_b = 1'b1; ctrl_d.reg_dst = REG_DST_RT;
            end
            OP_SLTI:  begin
               ctrl_d.alu_op = ALU_SLT; ctrl_d.alu_src_b = 1'b1;
               ctrl_d.ext_sel = 1'b1;  ctrl_d.reg_dst = REG_DST_RT;
            end
            OP_SW:    begin
               ctrl_d.alu_op = ALU_ADD; ctrl_d.alu_src_b = 1'b1; ctrl_d.ext_sel = 1'b1;
            end
            OP_LW:    begin
               ctrl_d.alu_op = ALU_ADD; ctrl_d.alu_src_b = 1'b1; ctrl_d.ext_sel = 1'b1;
               ctrl_d.reg_dst = REG_DST_RT; ctrl_d.db_data_src = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
               ctrl_d.alu_op = ALU_SUB; ctrl_d.ext_sel = 1'b1;
            end
            default: ;
         endcase
      end

      ctrl_d.reg_wre      = (next_state inside {S_WB_AL, S_WB_LD}) ||
                            ((next_state == S_ID) && (opcode == OP_JAL));
      ctrl_d.wr_reg_d_src = next_state inside {S_WB_AL, S_WB_LD};
      ctrl_d.m_rd         = (next_state == S_MEM) && (opcode == OP_LW);
      ctrl_d.m_wr         = (next_state == S_MEM) && (opcode == OP_SW);
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM with registered datapath controls.
// Optional performance counters are enabled with `define MC_CTRL_PERF_CNT_EN.
module mc_control_unit
   import mc_cpu_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [OPW-1:0]    opcode,
   input  logic              zero,
   input  logic              sign,
   output logic              PCWre,
   output logic [1:0]        PCSrc,
   output logic              IRWre,
   output logic              InsMemRW,
   output logic              RegWre,
   output logic [1:0]        RegDst,
   output logic              WrRegDSrc,
   output logic              ALUSrcA,
   output logic              ALUSrcB,
   output logic              ExtSel,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              mRD,
   output logic              mWR,
   output logic              DBDataSrc,
   output logic [2:0]        state
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]       cycle_cnt,
   output logic [31:0]       instr_cnt
`endif
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;

   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:     state_d = S_ID;
         S_ID: begin
            if (opcode == OP_HALT)         state_d = S_ID;
            else if (is_alu_op(opcode))    state_d = S_EXE_AL;
            else if (is_mem_op(opcode))    state_d = S_EXE_LS;
            else if (is_branch_op(opcode)) state_d = S_EXE_BR;
            else                           state_d = S_IF;
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         default:  state_d = S_IF;
      endcase
   end

   mc_ctrl_decode #(.OPW(OPW)) u_decode (
      .next_state (state_d),
      .opcode     (opcode),
      .zero       (zero),
      .sign       (sign),
      .ctrl_d     (ctrl_d)
   );

   // Controls load on the same edge as the state so PCWre never glitches.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IF;
         ctrl_q  <= CTRL_RESET;
      end else begin
         // NOTE: non-blocking so state and controls all update from pre-edge values.
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign PCWre     = ctrl_q.pc_wre;
   assign PCSrc     = ctrl_q.pc_src;
   assign IRWre     = ctrl_q.ir_wre;
   assign InsMemRW  = ctrl_q.ins_mem_rw;
   assign RegWre    = ctrl_q.reg_wre;
   assign RegDst    = ctrl_q.reg_dst;
   assign WrRegDSrc = ctrl_q.wr_reg_d_src;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign ALUSrcB   = ctrl_q.alu_src_b;
   assign ExtSel    = ctrl_q.ext_sel;
   assign ALUOp     = ctrl_q.alu_op;
   assign mRD       = ctrl_q.m_rd;
   assign mWR       = ctrl_q.m_wr;
   assign DBDataSrc = ctrl_q.db_data_src;
   assign state     = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;
   logic        halted;

   assign halted = (state_q == S_ID) && (opcode == OP_HALT);

   // instr_cnt counts with the PCWre pulse it accompanies, so it includes the current one.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (!halted)       cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (ctrl_d.pc_wre) instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected control vectors are queued
// when an opcode is issued and compared on each falling edge.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       Reset;
   logic [5:0] opcode;
   logic       zero, sign;
   logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
   logic       mRD, mWR, DBDataSrc;
   logic [1:0] PCSrc, RegDst;
   logic [2:0] ALUOp, state;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   typedef struct packed {
      logic [2:0] st;
      logic       pcwre;
      logic [1:0] pcsrc;
      logic       irwre;
      logic       insrw;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       srca;
      logic       srcb;
      logic       ext;
      logic [2:0] aluop;
      logic       mrd;
      logic       mwr;
      logic       dbsrc;
   } exp_t;

   exp_t sb[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   always #5 clk = ~clk;

   mc_control_unit dut (
      .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
      .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
      .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
      .DBDataSrc(DBDataSrc), .state(state)
`ifdef MC_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   function automatic exp_t actual();
      exp_t a;
      a = {state, PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
           ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc};
      return a;
   endfunction

   // Per-opcode datapath selects held from ID exit to the last state of the instruction.
   function automatic exp_t attrs(input logic [5:0] op);
      exp_t a = '0;
      case (op)
         6'b000000: begin a.aluop = 3'b000; a.regdst = 2'b10; end
         6'b000001: begin a.aluop = 3'b001; a.regdst = 2'b10; end
         6'b000010: begin a.aluop = 3'b000; a.srcb = 1; a.ext = 1; a.regdst = 2'b01; end
         6'b010000: begin a.aluop = 3'b010; a.regdst = 2'b10; end
         6'b010001: begin a.aluop = 3'b010; a.srcb = 1; a.regdst = 2'b01; end
         6'b010010: begin a.aluop = 3'b011; a.srcb = 1; a.regdst = 2'b01; end
         6'b100110: begin a.aluop = 3'b100; a.regdst = 2'b10; end
         6'b100111: begin a.aluop = 3'b100; a.srcb = 1; a.ext = 1; a.regdst = 2'b01; end
         6'b110000: begin a.aluop = 3'b000; a.srcb = 1; a.ext = 1; end
         6'b110001: begin a.aluop = 3'b000; a.srcb = 1; a.ext = 1; a.regdst = 2'b01; a.dbsrc = 1; end
         6'b110100, 6'b110101, 6'b110110: begin a.aluop = 3'b001; a.ext = 1; end
         default: ;
      endcase
      return a;
   endfunction

   task automatic push_instr(input logic [5:0] op, input logic z, input logic s);
      exp_t e;
      exp_t a = attrs(op);
      e = '0; e.st = 3'b001; e.regwre = (op == 6'b111010); sb.push_back(e);
      case (op)
         6'b000000, 6'b000001, 6'b000010, 6'b010000,
         6'b010001, 6'b010010, 6'b100110, 6'b100111: begin
            e = a; e.st = 3'b110; sb.push_back(e);
            e = a; e.st = 3'b111; e.regwre = 1; e.wrsrc = 1; sb.push_back(e);
         end
         6'b110000: begin
            e = a; e.st = 3'b010; sb.push_back(e);
            e = a; e.st = 3'b011; e.mwr = 1; sb.push_back(e);
         end
         6'b110001: begin
            e = a; e.st = 3'b010; sb.push_back(e);
            e = a; e.st = 3'b011; e.mrd = 1; sb.push_back(e);
            e = a; e.st = 3'b100; e.regwre = 1; e.wrsrc = 1; sb.push_back(e);
         end
         6'b110100, 6'b110101, 6'b110110: begin
            e = a; e.st = 3'b101; sb.push_back(e);
         end
         default: ;
      endcase
      e = '0; e.pcwre = 1; e.irwre = 1; e.insrw = 1;
      if ((op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s))
         e.pcsrc = 2'b01;
      else if (op == 6'b111001)
         e.pcsrc = 2'b10;
      else if (op == 6'b111000 || op == 6'b111010)
         e.pcsrc = 2'b11;
      sb.push_back(e);
   endtask

   // Called on the falling edge of an IF cycle; returns on the falling edge of the next IF.
   task automatic run_instr(input string name, input logic [5:0] op, input logic z, input logic s);
      exp_t exp_v, act_v;
      int   cyc = 0;
      opcode = op; zero = z; sign = s;
      push_instr(op, z, s);
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front();
         act_v = actual();
         total_cnt++;
         cyc++;
         if (act_v !== exp_v)
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act_v, exp_v);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_reset();
      exp_t rst_v = '0;
      rst_v.irwre = 1; rst_v.insrw = 1;
      Reset = 1'b0; opcode = 6'b000000; zero = 0; sign = 0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (actual() !== rst_v) $display("FAIL reset_hold: got %b want %b", actual(), rst_v);
      else pass_cnt++;
      Reset = 1'b1;
      #1;
      total_cnt++;
      if (actual() !== rst_v) $display("FAIL reset_release: got %b want %b", actual(), rst_v);
      else pass_cnt++;
   endtask

   task automatic test_alu();
      run_instr("add", 6'b000000, 0, 0);
      run_instr("sub", 6'b000001, 1, 0);
      run_instr("addiu", 6'b000010, 0, 1);
      run_instr("and", 6'b010000, 0, 0);
      run_instr("andi", 6'b010001, 0, 0);
      run_instr("ori", 6'b010010, 0, 0);
      run_instr("slt", 6'b100110, 0, 0);
      run_instr("slti", 6'b100111, 0, 0);
   endtask

   task automatic test_mem();
      run_instr("lw", 6'b110001, 0, 0);
      run_instr("sw", 6'b110000, 0, 0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", 6'b110100, 1, 0);
      run_instr("beq_not", 6'b110100, 0, 1);
      run_instr("bne_not", 6'b110101, 1, 0);
      run_instr("bne_taken", 6'b110101, 0, 0);
      run_instr("bltz_taken", 6'b110110, 0, 1);
      run_instr("bltz_not", 6'b110110, 1, 0);
   endtask

   task automatic test_jump();
      run_instr("jal", 6'b111010, 0, 0);
      run_instr("jr", 6'b111001, 0, 0);
      run_instr("j", 6'b111000, 1, 1);
      run_instr("undef_nop", 6'b101010, 1, 1);
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_lw", 6'b110001, 0, 0);
      run_instr("b2b_beq", 6'b110100, 1, 0);
      run_instr("b2b_jal", 6'b111010, 0, 0);
      run_instr("b2b_sub", 6'b000001, 0, 0);
      run_instr("b2b_nop", 6'b101010, 0, 0);
   endtask

   task automatic test_reset_mid_sw();
      opcode = 6'b110000; zero = 0; sign = 0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (state !== 3'b011 || mWR !== 1'b1)
         $display("FAIL rst_sw_mem: got state=%b mWR=%b want state=011 mWR=1", state, mWR);
      else pass_cnt++;
      #2 Reset = 1'b0;
      #1;
      total_cnt++;
      if (state !== 3'b000 || mWR !== 1'b0 || RegWre !== 1'b0 || PCWre !== 1'b0 || IRWre !== 1'b1)
         $display("FAIL rst_sw_abort: got state=%b mWR=%b RegWre=%b PCWre=%b IRWre=%b want 000 0 0 0 1",
                  state, mWR, RegWre, PCWre, IRWre);
      else pass_cnt++;
      @(negedge clk);
      Reset = 1'b1;
      #1;
      total_cnt++;
      if (state !== 3'b000 || PCWre !== 1'b0 || IRWre !== 1'b1 || mWR !== 1'b0)
         $display("FAIL rst_sw_release: got state=%b PCWre=%b IRWre=%b mWR=%b want 000 0 1 0",
                  state, PCWre, IRWre, mWR);
      else pass_cnt++;
   endtask

`ifdef MC_CTRL_PERF_CNT_EN
   task automatic test_perf();
      total_cnt++;
      if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0)
         $display("FAIL perf_reset: got cycle=%0d instr=%0d want 0 0", cycle_cnt, instr_cnt);
      else pass_cnt++;
      run_instr("perf_add", 6'b000000, 0, 0);
      run_instr("perf_nop", 6'b101010, 0, 0);
      total_cnt++;
      if (cycle_cnt !== 32'd6 || instr_cnt !== 32'd2)
         $display("FAIL perf_count: got cycle=%0d instr=%0d want 6 2", cycle_cnt, instr_cnt);
      else pass_cnt++;
   endtask
`endif

   task automatic test_halt();
      exp_t exp_v, act_v, id_v;
      id_v = '0; id_v.st = 3'b001;
      opcode = 6'b111111;
      repeat (20) sb.push_back(id_v);
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front();
         act_v = actual();
         total_cnt++;
         if (act_v !== exp_v) $display("FAIL halt_hold: got %b want %b", act_v, exp_v);
         else pass_cnt++;
      end
      Reset = 1'b0;
      #1;
      total_cnt++;
      if (state !== 3'b000 || IRWre !== 1'b1 || PCWre !== 1'b0)
         $display("FAIL halt_exit: got state=%b IRWre=%b PCWre=%b want 000 1 0", state, IRWre, PCWre);
      else pass_cnt++;
      @(negedge clk);
      Reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_jump();
      test_back_to_back();
      test_reset_mid_sw();
`ifdef MC_CTRL_PERF_CNT_EN
      test_perf();
`endif
      test_halt();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM that drives the program counter's PCWre/PCSrc inputs, plus every other datapath write-enable and mux select.
- Sequences IF -> ID -> EXE -> MEM -> WB per instruction, keyed on the IR opcode and the ALU zero/sign flags.
- Sits beside the datapath; its outputs feed the PC, IR, register file, ALU, data memory and muxes.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALUOp width.

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from the end of IF until the next IF
- zero  in  1  ALU result == 0
- sign  in  1  ALU result[31]
- PCWre  out  1  PC update pulse
- PCSrc  out  2  00 PC+4; 01 PC+4+imm*4; 10 RDout1; 11 jump addr
- IRWre  out  1  IR load
- InsMemRW  out  1  1 = instruction read
- RegWre  out  1  register-file write
- RegDst  out  2  00 $31; 01 rt; 10 rd
- WrRegDSrc  out  1  0 PC+4 (jal); 1 DB
- ALUSrcA  out  1  0 rs; 1 sa
- ALUSrcB  out  1  0 rt; 1 ext imm
- ExtSel  out  1  0 zero-extend; 1 sign-extend
- ALUOp  out  3  000 add; 001 sub; 010 and; 011 or; 100 slt
- mRD  out  1  data-memory read
- mWR  out  1  data-memory write
- DBDataSrc  out  1  0 ALU result; 1 memory data
- state  out  3  current FSM state, for debug

Behaviour:
- Opcodes:
  - ALU ops: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 100110, slti 100111
  - Memory: sw 110000, lw 110001
  - Branches: beq 110100, bne 110101, bltz 110110
  - Jumps: j 111000, jr 111001, jal 111010
  - halt 111111
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF -> ID.
  - ID -> EXE_AL for ALU ops, EXE_LS for sw/lw, EXE_BR for branches.
  - ID -> IF for j/jr/jal and for any undefined opcode (undefined = nop).
  - ID -> ID for halt.
  - EXE_AL -> WB_AL -> IF.
  - EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD -> IF for lw.
  - EXE_BR -> IF.
- Cycle counts: ALU op 4, lw 5, sw 4, branch 3, jump 2, nop 2.
- All outputs are registered.
  - Each output's next value is decoded from next_state, opcode, zero and sign, and loads on the same rising edge as the state register.
  - This makes PCWre glitch-free, which matters because the PC reacts to PCWre transitions.
- PCWre:
  - High for exactly one cycle: the first IF cycle after an instruction completes.
  - PCSrc is valid and stable throughout that cycle. It is 00 otherwise.
- Selects per instruction:
  - PCSrc = 01 for beq when zero=1, bne when zero=0, bltz when sign=1. Otherwise 00.
  - PCSrc = 10 for jr, 11 for j/jal.
  - zero/sign are sampled at the end of EXE_BR.
- IRWre=1 and InsMemRW=1 only in IF.
- RegWre=1 only in WB_AL, WB_LD, and in ID for jal (RegDst=00, WrRegDSrc=0).
- mRD=1 in MEM for lw only. mWR=1 in MEM for sw only.
- DBDataSrc=1 only for lw.
- ALUOp, ALUSrcA/B, ExtSel and RegDst hold their instruction values from the ID exit through the last state of that instruction.
- Branches use ALUOp=001 (sub) with ALUSrcB=0.
- halt:
  - FSM holds in ID with all enables 0; PC and IR are frozen.
  - Only Reset exits halt.
- Reset:
  - While Reset is low: state=IF and all outputs 0, except IRWre=1 and InsMemRW=1.
  - The first instruction is fetched from PC=0 with PCWre=0.
  - Reset asserted in any state aborts the instruction immediately. No write enable may stay high after Reset falls.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0]. Both are 0 on reset.
  - cycle_cnt increments every clk while not halted.
  - instr_cnt increments on each PCWre pulse.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mc_cpu_pkg holds:
  - opcode constants
  - state encodings
  - ALUOp, PCSrc and RegDst codes
- The PC and datapath use the same PCSrc/ALUOp constants from this package.
- One sub-module, mc_ctrl_decode: combinational decode of (next_state, opcode, zero, sign) to the next output vector.
- The top level holds the state and output registers.

Test Plan:
- Reset mid-MEM of sw -> mWR drops to 0 at once; state=000; after release, IF with PCWre=0.
- add (000000) -> states 000,001,110,111,000; RegWre=1 only in 111; RegDst=10; PCWre one cycle at the following IF with PCSrc=00.
- lw (110001) -> states 000,001,010,011,100; mRD=1 in 011; DBDataSrc=1 and RegWre=1 in 100.
- beq with zero=1 -> PCSrc=01 and PCWre=1 at the next IF. bne with zero=1 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- jal (111010) -> 2-cycle instruction; RegWre=1, RegDst=00, WrRegDSrc=0 in ID; next IF has PCWre=1, PCSrc=11. jr -> PCSrc=10.
- halt (111111) -> state stays 001 and PCWre stays 0 for 20 cycles. Undefined opcode 101010 -> nop with PCSrc=00.
